sha256_axilite_master: RTL and testbench

SHA256_AXILITE_MASTER -- requirements
Module: sha256_axilite_master

---
 rtl/sha256_axilite_master.sv | 275 +++++++++++++++++++++++++++
 tb/tb_sha256_axilite_master.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_axilite_master.sv
// AXI-lite master that streams 512-bit message blocks into a SHA-256 slave and returns the digest.
// Define SHA256_MASTER_SIGCHECK_EN to check the slave signature registers before the first soft reset.
module sha256_axilite_master #(
  parameter int POLL_LIMIT = 1024
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_last,
  output logic         dgst_valid,
  input  logic         dgst_ready,
  output logic [255:0] dgst_data,
  output logic         AWVALID,
  input  logic         AWREADY,
  output logic [7:0]   AWADDR,
  output logic [2:0]   AWPROT,
  output logic         WVALID,
  input  logic         WREADY,
  output logic [3:0]   WSTRB,
  output logic [31:0]  WDATA,
  input  logic         BVALID,
  output logic         BREADY,
  input  logic [1:0]   BRESP,
  output logic         ARVALID,
  input  logic         ARREADY,
  output logic [7:0]   ARADDR,
  output logic [2:0]   ARPROT,
  input  logic         RVALID,
  output logic         RREADY,
  input  logic [31:0]  RDATA,
  input  logic [1:0]   RRESP,
  output logic         busy,
  output logic         err
);

  localparam int PW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

`ifdef SHA256_MASTER_SIGCHECK_EN
  localparam logic [31:0] SIG_HI = 32'h73686132;
  localparam logic [31:0] SIG_LO = 32'h35360000;
  typedef enum logic [3:0] {SIG, SRST, IDLE, WBLK, PROC, DONE, RDIG, OUT, ERR} state_e;
  localparam state_e RESET_STATE = SIG;
`else
  typedef enum logic [3:0] {SRST, IDLE, WBLK, PROC, DONE, RDIG, OUT, ERR} state_e;
  localparam state_e RESET_STATE = SRST;
`endif

  state_e         state_q, state_d;
  logic           awvalid_q, awvalid_d;
  logic           wvalid_q, wvalid_d;
  logic           bready_q, bready_d;
  logic           arvalid_q, arvalid_d;
  logic           rready_q, rready_d;
  logic [7:0]     awaddr_q, awaddr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [7:0]     araddr_q, araddr_d;
  logic [511:0]   blk_q, blk_d;
  logic           last_q, last_d;
  logic [3:0]     idx_q, idx_d;
  logic [PW-1:0]  poll_q, poll_d;
  logic [255:0]   dgst_q, dgst_d;
  logic           err_q, err_d;

  logic           bus_idle, wr_fin, rd_fin, rsp_err;

  assign AWVALID    = awvalid_q;
  assign WVALID     = wvalid_q;
  assign BREADY     = bready_q;
  assign ARVALID    = arvalid_q;
  assign RREADY     = rready_q;
  assign AWADDR     = awaddr_q;
  assign WDATA      = wdata_q;
  assign ARADDR     = araddr_q;
  assign AWPROT     = 3'b000;
  assign ARPROT     = 3'b000;
  assign WSTRB      = 4'hF;
  assign blk_ready  = (state_q == IDLE);
  assign dgst_valid = (state_q == OUT);
  assign dgst_data  = dgst_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;

  // A new transaction may only start when every channel of the previous one has closed.
  assign bus_idle = !(awvalid_q || wvalid_q || bready_q || arvalid_q || rready_q);
  assign wr_fin   = bready_q && BVALID;
  assign rd_fin   = rready_q && RVALID;
  assign rsp_err  = (wr_fin && (BRESP != 2'b00)) || (rd_fin && (RRESP != 2'b00));

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= RESET_STATE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      blk_q     <= '0;
      last_q    <= 1'b0;
      idx_q     <= '0;
      poll_q    <= '0;
      dgst_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      araddr_q  <= araddr_d;
      blk_q     <= blk_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      poll_q    <= poll_d;
      dgst_q    <= dgst_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    araddr_d  = araddr_q;
    blk_d     = blk_q;
    last_d    = last_q;
    idx_d     = idx_q;
    poll_d    = poll_q;
    dgst_d    = dgst_q;
    err_d     = err_q;

    // AW and W close independently; B opens in the cycle the later of the two closes.
    if (awvalid_q && AWREADY) awvalid_d = 1'b0;
    if (wvalid_q && WREADY) wvalid_d = 1'b0;
    if ((awvalid_q || wvalid_q) && (!awvalid_q || AWREADY) && (!wvalid_q || WREADY))
      bready_d = 1'b1;
    if (wr_fin) bready_d = 1'b0;
    if (arvalid_q && ARREADY) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b1;
    end
    if (rd_fin) rready_d = 1'b0;

    case (state_q)
`ifdef SHA256_MASTER_SIGCHECK_EN
      SIG: begin
        if (bus_idle) begin
          arvalid_d = 1'b1;
          araddr_d  = idx_q[0] ? 8'hF8 : 8'hFC;
        end else if (rd_fin) begin
          if (rsp_err || (RDATA != (idx_q[0] ? SIG_LO : SIG_HI))) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else if (idx_q[0]) begin
            idx_d   = '0;
            state_d = SRST;
          end else begin
            idx_d = 4'd1;
          end
        end
      end
`endif
      SRST: begin
        if (bus_idle) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = 8'h60;
          wdata_d   = 32'h0;
        end else if (wr_fin) begin
          if (rsp_err) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (blk_valid) begin
          blk_d   = blk_data;
          last_d  = blk_last;
          idx_d   = '0;
          state_d = WBLK;
        end
      end
      WBLK: begin
        if (bus_idle) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = {2'b00, idx_q, 2'b00};
          wdata_d   = blk_q[{idx_q, 5'd0} +: 32];
        end else if (wr_fin) begin
          if (rsp_err) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else if (idx_q == 4'd15) begin
            idx_d   = '0;
            poll_d  = '0;
            state_d = PROC;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      PROC, DONE: begin
        if (bus_idle) begin
          arvalid_d = 1'b1;
          araddr_d  = (state_q == PROC) ? 8'h64 : 8'h68;
        end else if (rd_fin) begin
          if (rsp_err) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else if (RDATA[0]) begin
            poll_d = '0;
            idx_d  = '0;
            if (state_q == DONE) state_d = RDIG;
            else state_d = last_q ? DONE : IDLE;
          end else if (poll_q == POLL_LAST) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            poll_d = poll_q + PW'(1);
          end
        end
      end
      RDIG: begin
        if (bus_idle) begin
          arvalid_d = 1'b1;
          araddr_d  = {3'b010, idx_q[2:0], 2'b00};
        end else if (rd_fin) begin
          if (rsp_err) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            dgst_d[{idx_q[2:0], 5'd0} +: 32] = RDATA;
            if (idx_q == 4'd7) begin
              idx_d   = '0;
              state_d = OUT;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      end
      OUT: begin
        if (dgst_ready) state_d = IDLE;
      end
      ERR: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
      default: begin
        err_d   = 1'b1;
        state_d = ERR;
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_axilite_master.sv
// Directed bench for sha256_axilite_master: a SHA-256 computing AXI-lite slave plus a digest scoreboard.
// Honours SHA256_MASTER_SIGCHECK_EN when the design is built with it.
module tb_sha256_axilite_master;

  logic         ACLK = 1'b0;
  logic         ARESETn;
  logic         blk_valid, blk_ready, blk_last;
  logic [511:0] blk_data;
  logic         dgst_valid, dgst_ready;
  logic [255:0] dgst_data;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic         ARVALID, ARREADY, RVALID, RREADY;
  logic [7:0]   AWADDR, ARADDR;
  logic [2:0]   AWPROT, ARPROT;
  logic [3:0]   WSTRB;
  logic [31:0]  WDATA, RDATA;
  logic [1:0]   BRESP, RRESP;
  logic         busy, err;

  always #5 ACLK = ~ACLK;

  sha256_axilite_master #(.POLL_LIMIT(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .dgst_valid(dgst_valid), .dgst_ready(dgst_ready), .dgst_data(dgst_data),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WSTRB(WSTRB), .WDATA(WDATA),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .busy(busy), .err(err)
  );

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [511:0] ABC_BLOCK = 512'h61626380_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000018;
  localparam logic [255:0] ABC_DIGEST = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] TWO_B1 = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
  localparam logic [511:0] TWO_B2 = 512'h00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_000001c0;
  localparam logic [255:0] TWO_DIGEST = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`ifdef SHA256_MASTER_SIGCHECK_EN
  localparam int BOOT_SIG_READS = 2;
`else
  localparam int BOOT_SIG_READS = 0;
`endif

  int total = 0;
  int bad = 0;
  logic [255:0] expQ [$];

  int          proceedZerosCfg = 0;
  bit          doneNeverCfg = 0;
  logic [1:0]  brespCfg = 2'b00;
  int          awStallCfg = 0;
  logic [31:0] sigHiCfg = 32'h73686132;

  int sigReads = 0, srstWrites = 0, blockWrites = 0, proceedReads = 0, doneReads = 0;
  int dgstCount = 0, protoErr = 0;

  logic [31:0] mem [16];
  logic [31:0] H [8];
  bit          pending = 0, newMsg = 0;
  int          pdelay = 0;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Word 15 of the slave block holds the first message word, so the bench's block literals read naturally.
  function automatic void compress();
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = mem[15 - t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    a = H[0]; b = H[1]; c = H[2]; d = H[3]; e = H[4]; f = H[5]; g = H[6]; h = H[7];
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    H[0] += a; H[1] += b; H[2] += c; H[3] += d; H[4] += e; H[5] += f; H[6] += g; H[7] += h;
  endfunction

  task automatic slaveWrite(input logic [7:0] a, input logic [31:0] d);
    if (a < 8'h40) begin
      if (a == 8'h00 && newMsg) begin
        H = IV;
        newMsg = 0;
      end
      mem[a[5:2]] = d;
      blockWrites++;
      if (a == 8'h3C) begin
        pending = 1;
        pdelay = proceedZerosCfg;
      end
    end else if (a == 8'h60) begin
      srstWrites++;
      H = IV;
      newMsg = 0;
      pending = 0;
    end
  endtask

  task automatic slaveRead(input logic [7:0] a, output logic [31:0] d);
    d = 32'hDEADBEEF;
    if (a == 8'h64) begin
      proceedReads++;
      if (pdelay > 0) begin
        pdelay--;
        d = 32'h0;
      end else begin
        if (pending) compress();
        pending = 0;
        d = 32'h1;
      end
    end else if (a == 8'h68) begin
      doneReads++;
      if (doneNeverCfg) d = 32'h0;
      else begin
        d = 32'h1;
        newMsg = 1;
      end
    end else if (a == 8'hFC) begin
      sigReads++;
      d = sigHiCfg;
    end else if (a == 8'hF8) begin
      sigReads++;
      d = 32'h35360000;
    end else if (a >= 8'h40 && a <= 8'h5C) begin
      d = H[3'd7 - a[4:2]];
    end
  endtask

  // Slave and digest sink: act 1ns after each edge on what the previous edge handshook.
  initial begin
    bit          awHave, wHave, arHave;
    logic [7:0]  wAddr, rAddr;
    logic [31:0] wData, rData;
    int          awWait, dvWait;
    logic        pAWVALID, pWVALID, pARVALID, pBREADY, pRREADY, pDV;
    logic [7:0]  pAWADDR, pARADDR;
    logic [31:0] pWDATA;
    logic [255:0] pDgst;
    awHave = 0; wHave = 0; arHave = 0; awWait = 0; dvWait = 0;
    wAddr = 0; rAddr = 0; wData = 0; rData = 0;
    pAWVALID = 0; pWVALID = 0; pARVALID = 0; pBREADY = 0; pRREADY = 0; pDV = 0;
    pAWADDR = 0; pARADDR = 0; pWDATA = 0; pDgst = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; dgst_ready = 0;
    H = IV;
    forever begin
      @(posedge ACLK);
      #1;
      if (!ARESETn) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0; dgst_ready = 0;
        awHave = 0; wHave = 0; arHave = 0; awWait = 0; dvWait = 0;
        pAWVALID = 0; pWVALID = 0; pARVALID = 0; pBREADY = 0; pRREADY = 0; pDV = 0;
      end else begin
        if (pAWVALID && AWREADY) begin awHave = 1; wAddr = pAWADDR; end
        if (pWVALID && WREADY) begin wHave = 1; wData = pWDATA; end
        if (BVALID && pBREADY) BVALID = 0;
        if (pARVALID && ARREADY) begin arHave = 1; rAddr = pARADDR; end
        if (RVALID && pRREADY) RVALID = 0;
        if (pDV && dgst_ready) begin
          dgstCount++;
          if (expQ.size() == 0) checkOutput("dgst_unexpected", pDgst, 256'h0);
          else checkOutput("digest", pDgst, expQ.pop_front());
        end
        if (awHave && wHave) begin
          slaveWrite(wAddr, wData);
          awHave = 0; wHave = 0;
          BVALID = 1; BRESP = brespCfg;
        end
        if (arHave) begin
          slaveRead(rAddr, rData);
          RDATA = rData; RRESP = 2'b00; RVALID = 1; arHave = 0;
        end
        if (pAWVALID && !AWREADY && AWVALID && (AWADDR !== pAWADDR || WDATA !== pWDATA)) protoErr++;
        if ((ARVALID || RREADY) && (AWVALID || WVALID || BREADY)) protoErr++;
        if (BREADY && (AWVALID || WVALID)) protoErr++;
        if (pDV && !dgst_ready && dgst_valid && dgst_data !== pDgst) protoErr++;
        awWait = AWVALID ? awWait + 1 : 0;
        AWREADY = AWVALID && (awWait > awStallCfg);
        WREADY = 1; ARREADY = 1;
        dvWait = dgst_valid ? dvWait + 1 : 0;
        dgst_ready = (dvWait > 3);
        pAWVALID = AWVALID; pWVALID = WVALID; pARVALID = ARVALID;
        pBREADY = BREADY; pRREADY = RREADY; pDV = dgst_valid;
        pAWADDR = AWADDR; pARADDR = ARADDR; pWDATA = WDATA; pDgst = dgst_data;
      end
    end
  end

  task automatic applyStimulus(input logic [511:0] blk, input logic last);
    int n = 0;
    blk_data = blk; blk_last = last; blk_valid = 1;
    while (!blk_ready && n < 5000) begin @(negedge ACLK); n++; end
    checkOutput("blk_accept", blk_ready, 1'b1);
    @(negedge ACLK);
    blk_valid = 0;
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (!blk_ready && n < 2000) begin @(negedge ACLK); n++; end
    checkOutput(tag, blk_ready, 1'b1);
  endtask

  task automatic waitErr();
    int n = 0;
    while (!err && n < 2000) begin @(negedge ACLK); n++; end
  endtask

  task automatic waitDigest(input int target);
    int n = 0;
    while (dgstCount < target && n < 5000) begin @(negedge ACLK); n++; end
  endtask

  initial begin
    int base, bw0, dr0, d0, s0, sg0;
    ARESETn = 0; blk_valid = 0; blk_data = '0; blk_last = 0;
    repeat (3) @(negedge ACLK);
    checkOutput("rst_handshakes", {AWVALID, WVALID, BREADY, ARVALID, RREADY, blk_ready, dgst_valid, err}, 8'h00);
    checkOutput("rst_payload", {AWADDR, ARADDR, WDATA}, 48'h0);
    checkOutput("rst_dgst_data", dgst_data, 256'h0);
    checkOutput("rst_busy", busy, 1'b1);
    ARESETn = 1;
    waitReady("boot_ready");
    checkOutput("boot_sig_reads", sigReads, BOOT_SIG_READS);
    checkOutput("boot_srst_writes", srstWrites, 1);
    checkOutput("idle_busy", busy, 1'b0);

    $display("[TB] single block abc, PROCEED 0,0,0,1, AWREADY stalled");
    proceedZerosCfg = 3; awStallCfg = 5;
    base = proceedReads; d0 = dgstCount;
    expQ.push_back(ABC_DIGEST);
    applyStimulus(ABC_BLOCK, 1'b1);
    waitDigest(d0 + 1);
    repeat (10) @(negedge ACLK);
    checkOutput("abc_proceed_reads", proceedReads - base, 4);
    checkOutput("abc_dgst_pulses", dgstCount - d0, 1);
    checkOutput("abc_err", err, 1'b0);

    $display("[TB] two-block message");
    proceedZerosCfg = 0; awStallCfg = 0;
    bw0 = blockWrites; dr0 = doneReads; d0 = dgstCount;
    expQ.push_back(TWO_DIGEST);
    applyStimulus(TWO_B1, 1'b0);
    applyStimulus(TWO_B2, 1'b1);
    checkOutput("two_no_done_after_b1", doneReads - dr0, 0);
    waitDigest(d0 + 1);
    repeat (10) @(negedge ACLK);
    checkOutput("two_block_writes", blockWrites - bw0, 32);
    checkOutput("two_done_reads", doneReads - dr0, 1);
    checkOutput("two_dgst_pulses", dgstCount - d0, 1);

    $display("[TB] reset in the middle of WBLK");
    applyStimulus(ABC_BLOCK, 1'b1);
    base = 0;
    while (!(AWVALID && AWADDR == 8'h08) && base < 500) begin @(negedge ACLK); base++; end
    checkOutput("midrst_reach_word2", AWADDR, 8'h08);
    ARESETn = 0;
    @(negedge ACLK);
    checkOutput("midrst_no_valid", {AWVALID, WVALID, ARVALID}, 3'b000);
    s0 = srstWrites; sg0 = sigReads;
    ARESETn = 1;
    waitReady("midrst_ready");
    checkOutput("midrst_srst_writes", srstWrites - s0, 1);
    checkOutput("midrst_sig_reads", sigReads - sg0, BOOT_SIG_READS);

    $display("[TB] DONE never set with POLL_LIMIT 4");
    doneNeverCfg = 1;
    dr0 = doneReads;
    applyStimulus(ABC_BLOCK, 1'b1);
    waitErr();
    checkOutput("poll_err", err, 1'b1);
    checkOutput("poll_done_reads", doneReads - dr0, 4);
    repeat (5) @(negedge ACLK);
    checkOutput("err_quiet", {AWVALID, WVALID, ARVALID, BREADY, RREADY, blk_ready, dgst_valid}, 7'h00);
    checkOutput("err_doneReads_stop", doneReads - dr0, 4);

    $display("[TB] SLVERR on a block write");
    doneNeverCfg = 0;
    ARESETn = 0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1;
    waitReady("bresp_ready");
    checkOutput("rst_err_clear", err, 1'b0);
    brespCfg = 2'b10;
    bw0 = blockWrites;
    applyStimulus(ABC_BLOCK, 1'b1);
    waitErr();
    checkOutput("bresp_err", err, 1'b1);
    checkOutput("bresp_writes", blockWrites - bw0, 1);
    brespCfg = 2'b00;

`ifdef SHA256_MASTER_SIGCHECK_EN
    $display("[TB] signature mismatch");
    sigHiCfg = 32'h0;
    s0 = srstWrites;
    ARESETn = 0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1;
    waitErr();
    checkOutput("sig_err", err, 1'b1);
    checkOutput("sig_no_srst", srstWrites - s0, 0);
    sigHiCfg = 32'h73686132;
`endif

    checkOutput("scoreboard_empty", expQ.size(), 0);
    checkOutput("protocol", protoErr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
